// File: rtl/l1_icache_nway_pkg.sv
// mem_pkg: shared definitions for the L1 instruction cache.
//
// Purpose:
//   Default cache geometry and the address-split widths derived from it, the
//   cache line record used for the default geometry, and the controller state
//   encoding. The cache module takes its parameter defaults from here and
//   re-derives the same widths locally, so a non-default geometry still builds.
//
// Contents:
//   ICACHE_WAYS / ICACHE_SETS / ICACHE_BLOCK_BYTES   default geometry
//   ICACHE_OFF_BITS / ICACHE_IDX_BITS / ICACHE_TAG_BITS   derived address split
//   icache_line_t     one line: valid bit, tag, data block
//   icache_state_e    controller states (LOOKUP, REFILL)
package mem_pkg;

    localparam int ICACHE_WAYS        = 4;
    localparam int ICACHE_SETS        = 8;
    localparam int ICACHE_BLOCK_BYTES = 16;

    localparam int ICACHE_OFF_BITS = $clog2(ICACHE_BLOCK_BYTES);
    localparam int ICACHE_IDX_BITS = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_BITS = 32 - ICACHE_IDX_BITS - ICACHE_OFF_BITS;

    typedef struct packed {
        logic                            valid;
        logic [ICACHE_TAG_BITS-1:0]      tag;
        logic [8*ICACHE_BLOCK_BYTES-1:0] data;
    } icache_line_t;

    typedef enum logic {
        LOOKUP = 1'b0,
        REFILL = 1'b1
    } icache_state_e;

endpackage

// File: rtl/l1_icache_nway_lru.sv
// icache_lru: per-set true-LRU bookkeeping for the N-way instruction cache.
//
// Purpose:
//   Holds a rank per way per set (0 = most recently used, WAYS-1 = least).
//   Picks the refill victim for one set and applies one touch per cycle.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   vicIdx_i            set whose victim is requested
//   vicValid_i          valid bits of the ways in that set
//   victim_o            lowest invalid way, else the rank WAYS-1 way
//   upd_i               touch strobe (hit or fill)
//   updIdx_i, updWay_i  set and way being touched
module icache_lru
    import mem_pkg::*;
#(
    parameter int WAYS = ICACHE_WAYS,
    parameter int SETS = ICACHE_SETS,
    localparam int WW  = $clog2(WAYS),
    localparam int IW  = $clog2(SETS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [IW-1:0]   vicIdx_i,
    input  logic [WAYS-1:0] vicValid_i,
    output logic [WW-1:0]   victim_o,
    input  logic            upd_i,
    input  logic [IW-1:0]   updIdx_i,
    input  logic [WW-1:0]   updWay_i
);

    logic [WW-1:0] rank_q [SETS][WAYS];

    // Ranks start as the way index so an untouched set evicts the top way
    // first. A touch moves the way to rank 0 and ages only the ways that
    // were more recent than it, which keeps each set's ranks a permutation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    rank_q[s][w] <= WW'(w);
                end
            end
        end else if (upd_i) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WW'(w) == updWay_i) begin
                    rank_q[updIdx_i][w] <= '0;
                end else if (rank_q[updIdx_i][w] < rank_q[updIdx_i][updWay_i]) begin
                    rank_q[updIdx_i][w] <= rank_q[updIdx_i][w] + 1'b1;
                end
            end
        end
    end

    // Empty ways are filled lowest index first; only a full set falls back
    // to the least recently used way.
    always_comb begin
        logic found;
        found    = 1'b0;
        victim_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vicValid_i[w] && !found) begin
                victim_o = WW'(w);
                found    = 1'b1;
            end
        end
        if (!found) begin
            for (int w = 0; w < WAYS; w++) begin
                if (rank_q[vicIdx_i][w] == WW'(WAYS - 1)) begin
                    victim_o = WW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/l1_icache_nway.sv
// l1_icache_nway: parametrised N-way set-associative L1 instruction cache.
//
// Purpose:
//   Serves fetch hits combinationally, refills whole blocks from L2 on a
//   miss, invalidates lines hit by observed data-cache writes, supports
//   whole-cache invalidation (fence.i) and aborts a refill on pipeline flush.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   cpu_valid_i, cpu_addr_i        fetch request
//   cpu_ready_o, cpu_rdata_o       hit strobe and instruction word (0 when not ready)
//   flush_i                        abort an outstanding refill
//   inv_all_i                      clear every valid bit
//   snp_valid_i/wen_i/src_i/addr_i observed bus transaction
//   req_valid_o/addr_o/src_o/wen_o refill request to L2
//   mem_ready_i, mem_dst_i         L2 response strobe and destination ID
//   mem_rdata_i                    refill block
//   hit_cnt_o, miss_cnt_o          statistics (only with ICACHE_STATS_EN)
//
// Build option: define ICACHE_STATS_EN to add the hit/miss counters.
module l1_icache_nway
    import mem_pkg::*;
#(
    parameter int   WAYS        = ICACHE_WAYS,
    parameter int   SETS        = ICACHE_SETS,
    parameter int   BLOCK_BYTES = ICACHE_BLOCK_BYTES,
    parameter logic SRC_ID      = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cpu_valid_i,
    input  logic [31:0]              cpu_addr_i,
    output logic                     cpu_ready_o,
    output logic [31:0]              cpu_rdata_o,
    input  logic                     flush_i,
    input  logic                     inv_all_i,
    input  logic                     snp_valid_i,
    input  logic                     snp_wen_i,
    input  logic                     snp_src_i,
    input  logic [31:0]              snp_addr_i,
    output logic                     req_valid_o,
    output logic [31:0]              req_addr_o,
    output logic                     req_src_o,
    output logic                     req_wen_o,
    input  logic                     mem_ready_i,
    input  logic                     mem_dst_i,
    input  logic [8*BLOCK_BYTES-1:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]              hit_cnt_o,
    output logic [31:0]              miss_cnt_o
`endif
);

    localparam int OFF   = $clog2(BLOCK_BYTES);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = 32 - IDX - OFF;
    localparam int WW    = $clog2(WAYS);
    localparam int WORDS = BLOCK_BYTES / 4;
    localparam int WSEL  = OFF - 2;

    icache_state_e state_q, state_d;
    logic [TAG+IDX-1:0] blockAddr_q, blockAddr_d;
    logic stale_q, stale_d;
    logic [WAYS-1:0] valid_q [SETS];
    logic [WAYS-1:0] valid_d [SETS];
    logic [TAG-1:0] tagMem [SETS][WAYS];
    logic [8*BLOCK_BYTES-1:0] dataMem [SETS][WAYS];

    logic [IDX-1:0] cpuIdx, snpIdx, refIdx;
    logic [TAG-1:0] cpuTag, snpTag, refTag;
    logic [WSEL-1:0] cpuWord;
    logic hitAny, snoopWr, cpuReady, startMiss, busFree, memResp;
    logic snpBlkMatch, fillStale;
    logic [WW-1:0] hitWay, victim;
    logic [WAYS-1:0] snpHitVec;
    logic [31:0] hitWord;
    logic unusedBits;

    assign cpuIdx  = cpu_addr_i[OFF+IDX-1:OFF];
    assign cpuTag  = cpu_addr_i[31:OFF+IDX];
    assign cpuWord = cpu_addr_i[OFF-1:2];
    assign snpIdx  = snp_addr_i[OFF+IDX-1:OFF];
    assign snpTag  = snp_addr_i[31:OFF+IDX];
    assign refIdx  = blockAddr_q[IDX-1:0];
    assign refTag  = blockAddr_q[TAG+IDX-1:IDX];
    assign unusedBits = ^{cpu_addr_i[1:0], snp_addr_i[OFF-1:0]};

    // Parallel tag compare of every way for the fetch address and, in the
    // same cycle, for the observed bus address, then word select of the hit.
    always_comb begin
        logic [8*BLOCK_BYTES-1:0] hitLine;
        hitAny    = 1'b0;
        hitWay    = '0;
        snpHitVec = '0;
        hitWord   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[cpuIdx][w] && tagMem[cpuIdx][w] == cpuTag) begin
                if (!hitAny) begin
                    hitWay = WW'(w);
                end
                hitAny = 1'b1;
            end
            if (valid_q[snpIdx][w] && tagMem[snpIdx][w] == snpTag) begin
                snpHitVec[w] = 1'b1;
            end
        end
        hitLine = dataMem[cpuIdx][hitWay];
        for (int k = 0; k < WORDS; k++) begin
            if (cpuWord == WSEL'(k)) begin
                hitWord = hitLine[k*32 +: 32];
            end
        end
    end

    // An observed write owns the tag lookup for the cycle, so the fetch can
    // neither hit nor start a miss then. A response is ignored once flushed,
    // and the request is withdrawn in the very cycle the response lands.
    // A snoop or fence.i that coincides with the response counts as stale.
    always_comb begin
        snoopWr     = snp_valid_i & snp_wen_i;
        cpuReady    = (state_q == LOOKUP) & cpu_valid_i & hitAny & ~snoopWr;
        startMiss   = (state_q == LOOKUP) & cpu_valid_i & ~hitAny & ~snoopWr;
        busFree     = ~snp_valid_i | (snp_src_i == SRC_ID);
        memResp     = (state_q == REFILL) & mem_ready_i & (mem_dst_i == SRC_ID) & ~flush_i;
        snpBlkMatch = snoopWr & ({snpTag, snpIdx} == blockAddr_q);
        fillStale   = stale_q | inv_all_i | snpBlkMatch;
        req_valid_o = (state_q == REFILL) & busFree & ~flush_i & ~memResp;
        req_addr_o  = {blockAddr_q, {OFF{1'b0}}};
        req_src_o   = SRC_ID;
        req_wen_o   = 1'b0;
        cpu_ready_o = cpuReady;
        cpu_rdata_o = cpuReady ? hitWord : 32'h0;
    end

    // Controller next state: a miss latches the block and starts a fresh
    // (non-stale) refill; while refilling, anything that could make the
    // incoming block out of date marks it stale so it is installed invalid.
    always_comb begin
        state_d     = state_q;
        blockAddr_d = blockAddr_q;
        stale_d     = stale_q;
        case (state_q)
            LOOKUP: begin
                if (startMiss) begin
                    state_d     = REFILL;
                    blockAddr_d = {cpuTag, cpuIdx};
                    stale_d     = 1'b0;
                end
            end
            REFILL: begin
                if (snpBlkMatch || inv_all_i) begin
                    stale_d = 1'b1;
                end
                if (flush_i || memResp) begin
                    state_d = LOOKUP;
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    // Valid bits: a fill installs first, then snooped lines are dropped,
    // and fence.i wins over everything.
    always_comb begin
        valid_d = valid_q;
        if (memResp) begin
            valid_d[refIdx][victim] = ~fillStale;
        end
        if (snoopWr) begin
            for (int w = 0; w < WAYS; w++) begin
                if (snpHitVec[w]) begin
                    valid_d[snpIdx][w] = 1'b0;
                end
            end
        end
        if (inv_all_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_d[s] = '0;
            end
        end
    end

    // Control state and valid bits reset; a reset during a refill simply
    // abandons it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= LOOKUP;
            blockAddr_q <= '0;
            stale_q     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            state_q     <= state_d;
            blockAddr_q <= blockAddr_d;
            stale_q     <= stale_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data arrays are plain storage with no reset; they are only
    // meaningful behind a set valid bit.
    always_ff @(posedge clk_i) begin
        if (memResp) begin
            tagMem[refIdx][victim]  <= refTag;
            dataMem[refIdx][victim] <= mem_rdata_i;
        end
    end

    icache_lru #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_lru (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .vicIdx_i   (refIdx),
        .vicValid_i (valid_q[refIdx]),
        .victim_o   (victim),
        .upd_i      (cpuReady | memResp),
        .updIdx_i   (memResp ? refIdx : cpuIdx),
        .updWay_i   (memResp ? victim : hitWay)
    );

`ifdef ICACHE_STATS_EN
    logic [31:0] hitCnt_q, missCnt_q;

    // Free-running event counters that wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hitCnt_q  <= '0;
            missCnt_q <= '0;
        end else begin
            if (cpuReady) begin
                hitCnt_q <= hitCnt_q + 32'd1;
            end
            if (startMiss) begin
                missCnt_q <= missCnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hitCnt_q;
    assign miss_cnt_o = missCnt_q;
`endif

endmodule

// File: tb/tb_l1_icache_nway.sv
// tb_l1_icache_nway: self-checking bench for l1_icache_nway (default geometry).
//
// The reference model keeps, per set and way, the resident block address, a
// valid flag and a "last used" timestamp; LRU is the oldest timestamp. Line
// contents are a fixed function of the block address. Define ICACHE_STATS_EN
// to also exercise the statistics counters.
module tb_l1_icache_nway;

    localparam int   WAYS        = 4;
    localparam int   SETS        = 8;
    localparam int   BLOCK_BYTES = 16;
    localparam int   OFF         = 4;
    localparam logic SRC_ID      = 1'b0;

    logic clk, rst_n;
    logic cpu_valid, cpu_ready, flush, inv_all;
    logic [31:0] cpu_addr, cpu_rdata;
    logic snp_valid, snp_wen, snp_src;
    logic [31:0] snp_addr;
    logic req_valid, req_src, req_wen;
    logic [31:0] req_addr;
    logic mem_ready, mem_dst;
    logic [8*BLOCK_BYTES-1:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mBlk   [SETS][WAYS];
    bit          mVal   [SETS][WAYS];
    longint      mStamp [SETS][WAYS];
    longint      mNow;

    l1_icache_nway #(
        .WAYS(WAYS), .SETS(SETS), .BLOCK_BYTES(BLOCK_BYTES), .SRC_ID(SRC_ID)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cpu_valid_i(cpu_valid), .cpu_addr_i(cpu_addr),
        .cpu_ready_o(cpu_ready), .cpu_rdata_o(cpu_rdata),
        .flush_i(flush), .inv_all_i(inv_all),
        .snp_valid_i(snp_valid), .snp_wen_i(snp_wen), .snp_src_i(snp_src), .snp_addr_i(snp_addr),
        .req_valid_o(req_valid), .req_addr_o(req_addr), .req_src_o(req_src), .req_wen_o(req_wen),
        .mem_ready_i(mem_ready), .mem_dst_i(mem_dst), .mem_rdata_i(mem_rdata)
`ifdef ICACHE_STATS_EN
        , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a wait somewhere is never satisfied.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int setOf(logic [31:0] a);
        return int'((a >> OFF) % SETS);
    endfunction

    function automatic logic [31:0] blockOf(logic [31:0] a);
        return a & ~32'(BLOCK_BYTES - 1);
    endfunction

    function automatic logic [31:0] wordOf(logic [31:0] blk, int k);
        if (blk == 32'h100 && k == 1) return 32'hDEAD_BEEF;
        return (blk * 32'h9E37_79B9) ^ (32'(k) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [8*BLOCK_BYTES-1:0] lineOf(logic [31:0] blk);
        logic [8*BLOCK_BYTES-1:0] l;
        l = '0;
        for (int k = 0; k < BLOCK_BYTES / 4; k++) l[k*32 +: 32] = wordOf(blk, k);
        return l;
    endfunction

    task automatic modelReset();
        mNow = 0;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                mVal[s][w]   = 1'b0;
                mBlk[s][w]   = '0;
                mStamp[s][w] = -longint'(w);
            end
        end
    endtask

    function automatic int modelFind(logic [31:0] a);
        int s = setOf(a);
        for (int w = 0; w < WAYS; w++) if (mVal[s][w] && mBlk[s][w] == blockOf(a)) return w;
        return -1;
    endfunction

    task automatic modelTouch(int s, int w);
        mNow++;
        mStamp[s][w] = mNow;
    endtask

    task automatic modelFill(logic [31:0] a, bit stale);
        int s = setOf(a);
        int v = -1;
        for (int w = 0; w < WAYS; w++) if (!mVal[s][w] && v < 0) v = w;
        if (v < 0) begin
            v = 0;
            for (int w = 1; w < WAYS; w++) if (mStamp[s][w] < mStamp[s][v]) v = w;
        end
        mBlk[s][v] = blockOf(a);
        mVal[s][v] = !stale;
        modelTouch(s, v);
    endtask

    task automatic modelSnoop(logic [31:0] a);
        int s = setOf(a);
        for (int w = 0; w < WAYS; w++) if (mBlk[s][w] == blockOf(a)) mVal[s][w] = 1'b0;
    endtask

    task automatic modelInvAll();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mVal[s][w] = 1'b0;
    endtask

    task automatic idleInputs();
        cpu_valid = 0; cpu_addr = '0; flush = 0; inv_all = 0;
        snp_valid = 0; snp_wen = 0; snp_src = 0; snp_addr = '0;
        mem_ready = 0; mem_dst = 0; mem_rdata = '0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with the DUT reset.
    task automatic doReset();
        idleInputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();
    endtask

    // One fetch cycle; returns what the DUT showed mid-cycle.
    task automatic cpuAccess(input logic [31:0] a, output logic ready, output logic [31:0] data);
        cpu_valid = 1'b1;
        cpu_addr  = a;
        @(negedge clk);
        ready = cpu_ready;
        data  = cpu_rdata;
        @(posedge clk);
        #1 cpu_valid = 1'b0;
    endtask

    // Keeps the bus busy for a while, then waits (bounded) for the request
    // and answers it in the same cycle with the block's data.
    task automatic serviceRefill(input logic [31:0] blk, input int busyCycles, output bit sawReq,
                                 output logic [31:0] reqAddr, output int busyViol, output bit dropOk);
        sawReq = 0; reqAddr = '0; busyViol = 0; dropOk = 0;
        for (int i = 0; i < busyCycles; i++) begin
            snp_valid = 1'b1; snp_wen = 1'b0; snp_src = ~SRC_ID; snp_addr = $urandom;
            @(negedge clk);
            if (req_valid) busyViol++;
            @(posedge clk);
            #1;
        end
        snp_valid = 1'b0;
        for (int c = 0; c < 20 && !sawReq; c++) begin
            @(negedge clk);
            if (req_valid) begin
                sawReq  = 1;
                reqAddr = req_addr;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (sawReq) begin
            mem_ready = 1'b1; mem_dst = SRC_ID; mem_rdata = lineOf(blk);
            #1 dropOk = (req_valid == 1'b0);
            @(posedge clk);
            #1 mem_ready = 1'b0;
        end
    endtask

    // Miss followed by a normal refill; also checks the request address.
    task automatic missAndFill(input logic [31:0] a, input string tag);
        logic r; logic [31:0] d, ra; bit saw, drop; int bv;
        cpuAccess(a, r, d);
        checks++;
        if (r !== 1'b0) begin errors++; $display("[TB] FAIL %s_miss: got ready=%0b want 0", tag, r); end
        serviceRefill(blockOf(a), 0, saw, ra, bv, drop);
        checks++;
        if (!saw || ra !== blockOf(a)) begin
            errors++; $display("[TB] FAIL %s_req: got seen=%0b addr=%h want addr=%h", tag, saw, ra, blockOf(a));
        end
        modelFill(a, 1'b0);
    endtask

    task automatic test_reset();
        doReset();
        cpu_valid = 1'b1; cpu_addr = 32'h100;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_cpu: got ready=%0b data=%h want 0/0", cpu_ready, cpu_rdata);
        end
        checks++;
        if (req_valid !== 1'b0 || req_addr !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_req: got valid=%0b addr=%h want 0/0", req_valid, req_addr);
        end
        checks++;
        if (req_src !== SRC_ID || req_wen !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_const: got src=%0b wen=%0b want %0b/0", req_src, req_wen, SRC_ID);
        end
        @(posedge clk);
        #1 cpu_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL first_req: got valid=%0b addr=%h want 1/00000100", req_valid, req_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_midrefill: got valid=%0b want 0", req_valid); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();
        begin
            logic r; logic [31:0] d;
            cpuAccess(32'h100, r, d);
            checks++;
            if (r !== 1'b0) begin errors++; $display("[TB] FAIL reset_nofill: got ready=%0b want 0", r); end
        end
    endtask

    task automatic test_basic_refill();
        logic r; logic [31:0] d, ra; bit saw, drop; int bv;
        doReset();
        cpuAccess(32'h100, r, d);
        checks++;
        if (r !== 1'b0) begin errors++; $display("[TB] FAIL basic_miss: got ready=%0b want 0", r); end
        serviceRefill(32'h100, 0, saw, ra, bv, drop);
        checks++;
        if (ra !== 32'h100) begin errors++; $display("[TB] FAIL basic_reqaddr: got %h want 00000100", ra); end
        checks++;
        if (!drop) begin errors++; $display("[TB] FAIL basic_reqdrop: got req_valid=1 want 0 during response"); end
        modelFill(32'h100, 1'b0);
        cpuAccess(32'h104, r, d);
        checks++;
        if (r !== 1'b1 || d !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL basic_hit: got ready=%0b data=%h want 1/deadbeef", r, d);
        end
    endtask

    task automatic test_lru_eviction();
        logic r; logic [31:0] d;
        logic [31:0] blk [5];
        int order [5] = '{0, 1, 2, 3, 0};
        doReset();
        for (int i = 0; i < 5; i++) blk[i] = 32'h1000 + 32'(i) * 32'h80;
        for (int i = 0; i < 4; i++) missAndFill(blk[i], "lru_fill");
        for (int i = 0; i < 5; i++) begin
            cpuAccess(blk[order[i]] + 32'h8, r, d);
            checks++;
            if (r !== 1'b1 || d !== wordOf(blk[order[i]], 2)) begin
                errors++; $display("[TB] FAIL lru_touch%0d: got ready=%0b data=%h want 1/%h", i, r, d, wordOf(blk[order[i]], 2));
            end
            modelTouch(0, order[i]);
        end
        missAndFill(blk[4], "lru_fill5");
        for (int i = 0; i < 5; i++) begin
            if (i == 1) continue;
            cpuAccess(blk[i], r, d);
            checks++;
            if (r !== 1'b1) begin errors++; $display("[TB] FAIL lru_keep%0d: got ready=%0b want 1", i, r); end
        end
        cpuAccess(blk[1], r, d);
        checks++;
        if (r !== 1'b0) begin errors++; $display("[TB] FAIL lru_evicted: got ready=%0b want 0", r); end
        doReset();
    endtask

    task automatic test_snoop_hit();
        logic r; logic [31:0] d;
        doReset();
        missAndFill(32'h200, "snp_fill");
        missAndFill(32'h400, "snp_fill2");
        cpu_valid = 1; cpu_addr = 32'h200;
        snp_valid = 1; snp_wen = 1; snp_src = ~SRC_ID; snp_addr = 32'h208;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
            errors++; $display("[TB] FAIL snoop_stall: got ready=%0b data=%h want 0/0", cpu_ready, cpu_rdata);
        end
        @(posedge clk);
        #1 cpu_valid = 0; snp_valid = 0; snp_wen = 0;
        modelSnoop(32'h208);
        missAndFill(32'h200, "snoop_remiss");
        cpu_valid = 1; cpu_addr = 32'h200;
        snp_valid = 1; snp_wen = 1; snp_src = ~SRC_ID; snp_addr = 32'h400;
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b0) begin errors++; $display("[TB] FAIL snoop_other_stall: got ready=%0b want 0", cpu_ready); end
        @(posedge clk);
        #1 cpu_valid = 0; snp_valid = 0; snp_wen = 0;
        modelSnoop(32'h400);
        cpuAccess(32'h200, r, d);
        checks++;
        if (r !== 1'b1 || d !== wordOf(32'h200, 0)) begin
            errors++; $display("[TB] FAIL snoop_other_keep: got ready=%0b data=%h want 1/%h", r, d, wordOf(32'h200, 0));
        end
        modelTouch(setOf(32'h200), modelFind(32'h200));
        missAndFill(32'h400, "snoop_other_gone");
    endtask

    task automatic test_stale_refill();
        logic r; logic [31:0] d, ra; bit saw, drop; int bv;
        doReset();
        cpuAccess(32'h300, r, d);
        snp_valid = 1; snp_wen = 1; snp_src = ~SRC_ID; snp_addr = 32'h300;
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stale_busbusy: got req_valid=%0b want 0", req_valid); end
        @(posedge clk);
        #1 snp_valid = 0; snp_wen = 0;
        serviceRefill(32'h300, 0, saw, ra, bv, drop);
        checks++;
        if (!saw) begin errors++; $display("[TB] FAIL stale_req: got no request want request"); end
        modelFill(32'h300, 1'b1);
        missAndFill(32'h300, "stale_remiss");
        cpuAccess(32'h300, r, d);
        checks++;
        if (r !== 1'b1) begin errors++; $display("[TB] FAIL stale_finalhit: got ready=%0b want 1", r); end
    endtask

    task automatic test_flush();
        logic r; logic [31:0] d;
        doReset();
        cpuAccess(32'h500, r, d);
        @(negedge clk);
        checks++;
        if (req_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_prereq: got req_valid=%0b want 1", req_valid); end
        flush = 1'b1;
        #1;
        checks++;
        if (req_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_drop: got req_valid=%0b want 0", req_valid); end
        @(posedge clk);
        #1 flush = 1'b0;
        mem_ready = 1; mem_dst = SRC_ID; mem_rdata = lineOf(32'h500);
        @(posedge clk);
        #1 mem_ready = 0;
        missAndFill(32'h500, "flush_nofill");
        flush = 1'b1;
        cpuAccess(32'h504, r, d);
        flush = 1'b0;
        checks++;
        if (r !== 1'b1 || d !== wordOf(32'h500, 1)) begin
            errors++; $display("[TB] FAIL flush_lookup: got ready=%0b data=%h want 1/%h", r, d, wordOf(32'h500, 1));
        end
    endtask

    task automatic test_inv_all();
        logic r; logic [31:0] d, ra; bit saw, drop; int bv;
        doReset();
        missAndFill(32'h600, "inv_fill");
        inv_all = 1'b1;
        @(posedge clk);
        #1 inv_all = 1'b0;
        modelInvAll();
        cpuAccess(32'h600, r, d);
        checks++;
        if (r !== 1'b0) begin errors++; $display("[TB] FAIL inv_miss: got ready=%0b want 0", r); end
        inv_all = 1'b1;
        @(posedge clk);
        #1 inv_all = 1'b0;
        serviceRefill(32'h600, 0, saw, ra, bv, drop);
        modelFill(32'h600, 1'b1);
        cpuAccess(32'h600, r, d);
        checks++;
        if (r !== 1'b0) begin errors++; $display("[TB] FAIL inv_refill_stale: got ready=%0b want 0", r); end
        doReset();
    endtask

    task automatic test_random();
        logic r; logic [31:0] a, b, d, ra; bit saw, drop; int bv, sel, way;
        doReset();
        for (int it = 0; it < 300; it++) begin
            sel = int'($urandom_range(0, 15));
            a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            if (sel == 0) begin
                inv_all = 1'b1;
                @(posedge clk);
                #1 inv_all = 1'b0;
                modelInvAll();
            end else if (sel < 3) begin
                b = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 7)) << 4);
                cpu_valid = 1; cpu_addr = a;
                snp_valid = 1; snp_wen = 1; snp_src = 1'($urandom); snp_addr = b;
                @(negedge clk);
                checks++;
                if (cpu_ready !== 1'b0 || cpu_rdata !== 32'h0) begin
                    errors++; $display("[TB] FAIL rnd_snoop it=%0d: got ready=%0b data=%h want 0/0", it, cpu_ready, cpu_rdata);
                end
                @(posedge clk);
                #1 cpu_valid = 0; snp_valid = 0; snp_wen = 0;
                modelSnoop(b);
            end else begin
                way = modelFind(a);
                cpuAccess(a, r, d);
                if (way >= 0) begin
                    checks++;
                    if (r !== 1'b1 || d !== wordOf(blockOf(a), int'(a[3:2]))) begin
                        errors++; $display("[TB] FAIL rnd_hit it=%0d addr=%h: got ready=%0b data=%h want 1/%h", it, a, r, d, wordOf(blockOf(a), int'(a[3:2])));
                    end
                    modelTouch(setOf(a), way);
                end else begin
                    checks++;
                    if (r !== 1'b0 || d !== 32'h0) begin
                        errors++; $display("[TB] FAIL rnd_miss it=%0d addr=%h: got ready=%0b data=%h want 0/0", it, a, r, d);
                    end
                    serviceRefill(blockOf(a), int'($urandom_range(0, 2)), saw, ra, bv, drop);
                    checks++;
                    if (!saw || ra !== blockOf(a) || bv != 0) begin
                        errors++; $display("[TB] FAIL rnd_req it=%0d: got seen=%0b addr=%h busyviol=%0d want 1/%h/0", it, saw, ra, bv, blockOf(a));
                    end
                    modelFill(a, 1'b0);
                end
            end
        end
    endtask

`ifdef ICACHE_STATS_EN
    task automatic test_stats();
        logic r; logic [31:0] d;
        doReset();
        missAndFill(32'h700, "stats_a");
        missAndFill(32'h780, "stats_b");
        cpuAccess(32'h700, r, d);
        cpuAccess(32'h780, r, d);
        cpuAccess(32'h700, r, d);
        @(negedge clk);
        checks++;
        if (hit_cnt !== 32'd3 || miss_cnt !== 32'd2) begin
            errors++; $display("[TB] FAIL stats_counts: got hits=%0d misses=%0d want 3/2", hit_cnt, miss_cnt);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        idleInputs();
        rst_n = 1'b0;
        test_reset();
        test_basic_refill();
        test_lru_eviction();
        test_snoop_hit();
        test_stale_refill();
        test_flush();
        test_inv_all();
        test_random();
`ifdef ICACHE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l1_icache_nway.md
# l1_icache_nway

Parametrised N-way set-associative L1 instruction cache, successor to the fixed 4-way instruction cache. Sits between the fetch stage and the shared L1→L2 bus. Serves hits in the same cycle and refills whole blocks from L2 on a miss. Snoops data-cache writes on the bus for coherence and adds per-set true LRU, whole-cache invalidation (fence.i) and refill abort on pipeline flush.

## Interface
- WAYS, 4, associativity; power of two, 2..8
- SETS, 8, sets per way; power of two ≥2
- BLOCK_BYTES, 16, line size in bytes; power of two, 8..64
- SRC_ID, 1'b0, this cache's bus source/destination ID
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- cpu_valid_i  in  1  fetch request valid
- cpu_addr_i  in  32  fetch byte address; bits [1:0] ignored
- cpu_ready_o  out  1  rdata valid this cycle (hit)
- cpu_rdata_o  out  32  fetched instruction word
- flush_i  in  1  pipeline flush; aborts an outstanding refill
- inv_all_i  in  1  invalidate every line (fence.i)
- snp_valid_i  in  1  bus transaction valid (observed bus)
- snp_wen_i  in  1  observed transaction is a write
- snp_src_i  in  1  observed transaction source ID
- snp_addr_i  in  32  observed transaction address
- req_valid_o  out  1  refill request to L2
- req_addr_o  out  32  block-aligned refill address
- req_src_o  out  1  constant SRC_ID
- req_wen_o  out  1  constant 0
- mem_ready_i  in  1  L2 response valid
- mem_dst_i  in  1  response destination ID
- mem_rdata_i  in  8*BLOCK_BYTES  refill line

## Operation
- Address split: OFF = log2(BLOCK_BYTES), IDX = log2(SETS), TAG = 32−IDX−OFF. Word select = addr[OFF−1:2].
- The FSM has two states:
  - LOOKUP (reset state):
    - Tag-compare all ways at cpu_addr_i.
    - A snoop write (snp_valid_i & snp_wen_i) takes priority. It compares snp_addr_i instead; a matching line's valid bit clears at the next edge, and cpu_ready_o = 0 that cycle.
    - Otherwise a hit gives cpu_ready_o = 1 and cpu_rdata_o = the selected word.
    - A miss with cpu_valid_i set latches the block address and enters REFILL.
  - REFILL:
    - The cache asserts req_valid_o only when the bus is free (!snp_valid_i or snp_src_i == SRC_ID). Otherwise it holds req_valid_o = 0 and retries each cycle.
    - On mem_ready_i & mem_dst_i == SRC_ID, the victim line gets the data and tag at the edge. Valid is set unless the stale flag is set. The FSM returns to LOOKUP and req_valid_o drops in the same cycle as the response.
- Victim choice: lowest-index invalid way; otherwise the LRU way of that set.
- LRU: per set, a rank of log2(WAYS) bits per way. On a hit or fill the touched way becomes rank 0, and ways with smaller rank increment. Snoop invalidation leaves ranks unchanged.
- Stale flag: set when a snoop write in REFILL matches the latched block address. It is cleared on entering REFILL.
- flush_i in REFILL: drop req_valid_o combinationally, go to LOOKUP, install nothing. flush_i in LOOKUP has no effect.
- inv_all_i: clears all valid bits at the next edge in any state. In REFILL it also sets the stale flag.
- cpu_rdata_o = 0 whenever cpu_ready_o = 0.

## Timing
- Reset (async assert) clears all valid bits, sets LRU rank = way index, state = LOOKUP, stale = 0. Outputs are then cpu_ready_o 0, cpu_rdata_o 0, req_valid_o 0, req_addr_o 0. Tag and data arrays are not reset.
- Hit latency: 0 cycles (combinational from cpu_addr_i).
- Miss: REFILL is entered at edge N. The earliest req_valid_o is cycle N. After a response at edge M, the hit is seen in cycle M (LOOKUP).
- Reset mid-refill: the request is dropped immediately and no line is installed.
- A simultaneous snoop hit and CPU hit on different lines still stalls the CPU for one cycle.

## Configuration
- ICACHE_STATS_EN:
  - Defined: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
    - hit_cnt_o increments on each cycle with cpu_ready_o.
    - miss_cnt_o increments on each LOOKUP→REFILL transition.
    - Both are reset to 0 and wrap at 2^32.
  - Undefined: the ports and counters are absent, with identical other behaviour.

## Structure
- mem_pkg gains the following, each computed from the parameters: icache_line_t (Valid, Tag, Data), ICACHE_OFF_BITS, ICACHE_IDX_BITS, ICACHE_TAG_BITS.
- Sub-module icache_lru: per-set rank storage, victim select, and update port.

## Test plan
- Reset, read 0x0000_0100 → miss; req_addr_o = 0x100. Respond with a line whose word 1 = 0xDEAD_BEEF → read 0x104 gives ready = 1 with 0xDEAD_BEEF the cycle after the response.
- Fill 5 blocks mapping to set 0 with WAYS=4; touch ways in order 0,1,2,3, then re-hit way 0 → 5th fill evicts way 1.
- Hit on 0x200 while a snoop write to 0x208 (src ≠ SRC_ID) arrives → ready = 0 that cycle; next access to 0x200 misses.
- Miss on 0x300, snoop write to 0x300 during REFILL, then respond → line not valid; re-access misses again.
- Miss, then flush_i before the response → req_valid_o drops the same cycle, no fill; a late response with dst = SRC_ID is ignored.
- ICACHE_STATS_EN: 3 hits and 2 misses → hit_cnt_o = 3, miss_cnt_o = 2; inv_all_i followed by a hit address gives a miss.
